// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encodings and legal width range.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Data/control bundle of the universal shift register; master drives mode and data, slave is the register.
interface univ_shift_reg_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;
    logic             sout_r;
    logic             sout_l;
    logic             word_done;

    modport master (
        output mode, sin_r, sin_l, pin,
        input  Q, Qbar, sout_r, sout_l, word_done
    );

    modport slave (
        input  mode, sin_r, sin_l, pin,
        output Q, Qbar, sout_r, sout_l, word_done
    );
endinterface

// File: rtl/d_ff_cell.sv
// Single-bit D flip-flop with asynchronous active-low clear and preset; clear dominates.
module d_ff_cell (
    input  logic clk,
    input  logic clr_bar,
    input  logic pre_bar,
    input  logic D,
    output logic Q,
    output logic Qbar
);

    always_ff @(posedge clk or negedge clr_bar or negedge pre_bar) begin
        if (!clr_bar)
            Q <= 1'b0;
        else if (!pre_bar)
            Q <= 1'b1;
        else
            Q <= D;
    end

    // Qbar derived from Q so the cell can never present Q = Qbar = 1.
    assign Qbar = ~Q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with a word-complete pulse.
// Define SHIFT_REG_RING_EN to feed the outgoing bit back in, turning shifts into rotations.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              clr_bar,
    input  logic              pre_bar,
    univ_shift_reg_if.slave   bus
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("univ_shift_reg: WIDTH out of range");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] d_next;
    logic             ser_r;
    logic             ser_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done_r;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

`ifdef SHIFT_REG_RING_EN
    assign ser_r = q[0];
    assign ser_l = q[WIDTH-1];
`else
    assign ser_r = bus.sin_r;
    assign ser_l = bus.sin_l;
`endif

    always_comb begin
        d_next = q;
        case (mode)
            MODE_HOLD: d_next = q;
            MODE_SHR:  d_next = {ser_r, q[WIDTH-1:1]};
            MODE_SHL:  d_next = {q[WIDTH-2:0], ser_l};
            MODE_LOAD: d_next = bus.pin;
            default:   d_next = q;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_ff_cell u_cell (
            .clk     (clk),
            .clr_bar (clr_bar),
            .pre_bar (pre_bar),
            .D       (d_next[i]),
            .Q       (q[i]),
            .Qbar    (qbar[i])
        );
    end

    // Either async event abandons the word in progress, so both clear the count.
    always_ff @(posedge clk or negedge clr_bar or negedge pre_bar) begin
        if (!clr_bar) begin
            shift_cnt   <= '0;
            word_done_r <= 1'b0;
        end else if (!pre_bar) begin
            shift_cnt   <= '0;
            word_done_r <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            case (mode)
                MODE_SHR, MODE_SHL: begin
                    if (shift_cnt == CNT_LAST) begin
                        shift_cnt   <= '0;
                        word_done_r <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                MODE_LOAD: shift_cnt <= '0;
                default:   shift_cnt <= shift_cnt;
            endcase
        end
    end

    assign bus.Q         = q;
    assign bus.Qbar      = qbar;
    assign bus.sout_r    = q[0];
    assign bus.sout_l    = q[WIDTH-1];
    assign bus.word_done = word_done_r;

endmodule
